// File: rtl/fitness_evaluator_if.sv
// Handshake and data bundle between the evolution controller/candidate
// harness (master) and the fitness evaluator (slave).
interface fitness_evaluator_if;
   logic        start;
   logic [63:0] target_table;
   logic [3:0]  dut_out;
   logic [3:0]  dut_in;
   logic        busy;
   logic        done;
   logic [19:0] out_hits;
   logic [6:0]  score;
   logic        perfect;

   modport master (
      output start, target_table, dut_out,
      input  dut_in, busy, done, out_hits, score, perfect
   );

   modport slave (
      input  start, target_table, dut_out,
      output dut_in, busy, done, out_hits, score, perfect
   );
endinterface

// File: rtl/fitness_evaluator.sv
// Fitness evaluator for an evolved 4-in/4-out combinational candidate.
// Steps the candidate through all 16 input rows, lets each row settle for
// SETTLE_CYCLES clocks, samples the outputs once, and accumulates per-output
// hit counts and a total score against a target truth table.
module fitness_evaluator #(
   parameter int SETTLE_CYCLES = 8
) (
   input  logic               clk,
   input  logic               reset,
   fitness_evaluator_if.slave bus
);

   localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t           state;
   state_t           state_n;
   logic [3:0]       row;
   logic [CNT_W-1:0] settle_cnt;
   logic [3:0]       dut_in_r;
   logic [19:0]      hits;
   logic [6:0]       score_r;
   logic             perfect_r;
   logic             done_r;
   logic [3:0]       match;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   // Candidate output bits that agree with the target row currently applied.
   assign match = ~(bus.dut_out ^ bus.target_table[{row, 2'b00} +: 4]);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic: one SAMPLE cycle per row, DONE after row 15.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = SETTLE;
         SETTLE:  if (settle_cnt == '0) state_n = SAMPLE;
         SAMPLE:  state_n = (row == 4'hF) ? DONE : SETTLE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Row stepping, settle timing and score accumulation; done is registered
   // on the DONE->IDLE edge so it pulses for exactly one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row        <= '0;
         settle_cnt <= '0;
         dut_in_r   <= '0;
         hits       <= '0;
         score_r    <= '0;
         perfect_r  <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  row        <= '0;
                  dut_in_r   <= '0;
                  settle_cnt <= CNT_LOAD;
                  hits       <= '0;
                  score_r    <= '0;
                  perfect_r  <= 1'b0;
               end
            end
            SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            end
            SAMPLE: begin
               for (int j = 0; j < 4; j++)
                  hits[5*j +: 5] <= hits[5*j +: 5] + 5'(match[j]);
               score_r <= score_r + 7'(popcount4(match));
               if (row != 4'hF) begin
                  row        <= row + 4'd1;
                  dut_in_r   <= row + 4'd1;
                  settle_cnt <= CNT_LOAD;
               end
            end
            DONE: begin
               done_r    <= 1'b1;
               perfect_r <= (score_r == 7'd64);
            end
            default: ;
         endcase
      end
   end

   assign bus.dut_in   = dut_in_r;
   assign bus.busy     = (state == SETTLE) || (state == SAMPLE);
   assign bus.done     = done_r;
   assign bus.out_hits = hits;
   assign bus.score    = score_r;
   assign bus.perfect  = perfect_r;

endmodule

// File: tb/tb_fitness_evaluator.sv
// Bench for fitness_evaluator: a combinational candidate model drives
// dut_out, a timeline model predicts every output each cycle, and directed
// runs pin the model with hand-computed results.
module tb_fitness_evaluator;

   localparam int S   = 8;
   localparam int P   = S + 1;        // edges spent per row
   localparam int RUN = 16 * P + 1;   // edges from accepted start to done

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   mode  = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   fitness_evaluator_if bus ();

   fitness_evaluator #(.SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Candidate circuit: 0 identity, 1 inverter, 2 out1=in1 with others stuck 0.
   function automatic logic [3:0] cand(input int md, input logic [3:0] x);
      case (md)
         0:       return x;
         1:       return ~x;
         default: return x & 4'b0010;
      endcase
   endfunction

   always_comb bus.dut_out = cand(mode, bus.dut_in);

   function automatic logic [63:0] ident_table();
      logic [63:0] t;
      for (int r = 0; r < 16; r++) t[4*r +: 4] = 4'(r);
      return t;
   endfunction

   function automatic logic [3:0] row_match(input int r);
      logic [63:0] t;
      t = bus.target_table;
      return ~(cand(mode, 4'(r)) ^ t[4*r +: 4]);
   endfunction

   function automatic int score_of(input int rows);
      int s = 0;
      for (int r = 0; r < rows; r++) begin
         logic [3:0] m;
         m = row_match(r);
         for (int j = 0; j < 4; j++) s += int'(m[j]);
      end
      return s;
   endfunction

   function automatic logic [19:0] hits_of(input int rows);
      int h [4];
      for (int j = 0; j < 4; j++) h[j] = 0;
      for (int r = 0; r < rows; r++) begin
         logic [3:0] m;
         m = row_match(r);
         for (int j = 0; j < 4; j++) h[j] += int'(m[j]);
      end
      return {5'(h[3]), 5'(h[2]), 5'(h[1]), 5'(h[0])};
   endfunction

   // Timeline model: age counts edges since the accepted start.
   bit         running;
   int         age;
   int         m_rows;
   logic [3:0] m_idle_in;
   bit         m_perfect;
   bit         m_done;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         running   <= 1'b0;
         age       <= 0;
         m_rows    <= 0;
         m_idle_in <= 4'h0;
         m_perfect <= 1'b0;
         m_done    <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (running) begin
            if (age + 1 == RUN) begin
               running   <= 1'b0;
               m_done    <= 1'b1;
               m_rows    <= 16;
               m_idle_in <= 4'hF;
               m_perfect <= (score_of(16) == 64);
            end else begin
               age <= age + 1;
            end
         end else if (bus.start) begin
            running   <= 1'b1;
            age       <= 0;
            m_perfect <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Advance one cycle and compare every output against the model.
   task automatic tick();
      int         rows;
      logic [3:0] e_in;
      bit         e_busy;
      @(negedge clk);
      if (!reset) begin
         if (running) begin
            rows   = (age / P > 16) ? 16 : age / P;
            e_busy = (age < 16 * P);
            e_in   = (age < 16 * P) ? 4'(age / P) : 4'hF;
         end else begin
            rows   = m_rows;
            e_busy = 1'b0;
            e_in   = m_idle_in;
         end
         chk("cyc_done",     bus.done,     m_done);
         chk("cyc_busy",     bus.busy,     e_busy);
         chk("cyc_dut_in",   bus.dut_in,   e_in);
         chk("cyc_score",    bus.score,    score_of(rows));
         chk("cyc_out_hits", bus.out_hits, hits_of(rows));
         chk("cyc_perfect",  bus.perfect,  m_perfect);
      end
   endtask

   task automatic run_eval(input int md, input bit pulse, output int lat);
      int c0;
      mode      = md;
      bus.start = 1'b1;
      tick();
      c0        = cyc;
      bus.start = 1'b0;
      lat       = -1;
      for (int i = 0; i < 400; i++) begin
         bus.start = pulse && (bus.dut_in == 4'd3 || bus.dut_in == 4'd9);
         tick();
         if (bus.done) begin
            lat = cyc - c0;
            break;
         end
      end
      bus.start = 1'b0;
      if (lat < 0) chk("done_timeout", 0, 1);
      else begin
         tick();
         chk("done_width", bus.done, 0);
      end
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (bus.done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("wait_done_timeout", 0, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dut_in"},   bus.dut_in,   0);
      chk({tag, "_busy"},     bus.busy,     0);
      chk({tag, "_done"},     bus.done,     0);
      chk({tag, "_out_hits"}, bus.out_hits, 0);
      chk({tag, "_score"},    bus.score,    0);
      chk({tag, "_perfect"},  bus.perfect,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          c0;
      int          prev;
      int          dn;
      int          seen;
      logic [19:0] h_all16;
      logic [19:0] h_stuck;
      h_all16 = {5'd16, 5'd16, 5'd16, 5'd16};
      h_stuck = {5'd8, 5'd8, 5'd16, 5'd8};

      bus.start        = 1'b0;
      bus.target_table = ident_table();
      mode             = 0;
      reset            = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Identity candidate against identity table.
      run_eval(0, 1'b0, lat);
      chk("id_latency",  lat,          RUN);
      chk("id_score",    bus.score,    64);
      chk("id_out_hits", bus.out_hits, h_all16);
      chk("id_perfect",  bus.perfect,  1);
      repeat (5) tick();
      chk("id_hold_score", bus.score, 64);

      // Inverting candidate.
      run_eval(1, 1'b0, lat);
      chk("inv_score",    bus.score,    0);
      chk("inv_out_hits", bus.out_hits, 0);
      chk("inv_perfect",  bus.perfect,  0);

      // Only output 1 follows its input.
      run_eval(2, 1'b0, lat);
      chk("stuck_score",    bus.score,    40);
      chk("stuck_out_hits", bus.out_hits, h_stuck);
      chk("stuck_perfect",  bus.perfect,  0);

      // Extra starts during rows 3 and 9 are ignored.
      run_eval(0, 1'b1, lat);
      chk("pulse_latency", lat,       RUN);
      chk("pulse_score",   bus.score, 64);

      // Inverted target with inverting candidate is a perfect match.
      bus.target_table = ~ident_table();
      run_eval(1, 1'b0, lat);
      chk("invtgt_score",   bus.score,   64);
      chk("invtgt_perfect", bus.perfect, 1);

      // Arbitrary target, checked by the model only.
      bus.target_table = {$urandom, $urandom};
      run_eval(0, 1'b0, lat);
      bus.target_table = ident_table();

      // start held high across three back-to-back evaluations.
      mode      = 0;
      bus.start = 1'b1;
      tick();
      c0   = cyc;
      prev = c0;
      for (int k = 0; k < 3; k++) begin
         wait_done(dn);
         if (k == 2) bus.start = 1'b0;
         if (dn >= 0) chk("held_gap", dn - prev, (k == 0) ? RUN : RUN + 1);
         prev = dn;
      end
      bus.start = 1'b0;
      repeat (10) tick();
      chk("held_idle_busy", bus.busy, 0);

      // Asynchronous reset in the middle of row 7's settle window.
      mode      = 2;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.dut_in == 4'd7) begin
            seen = 1;
            break;
         end
      end
      chk("row7_reached", seen, 1);
      repeat (3) tick();
      #2 reset = 1'b1;
      #1 chk_all_zero("midreset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
      run_eval(2, 1'b0, lat);
      chk("post_reset_latency",  lat,          RUN);
      chk("post_reset_score",    bus.score,    40);
      chk("post_reset_out_hits", bus.out_hits, h_stuck);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
